// File: rtl/read_pointer_level_pkg.sv
// Pointer helpers shared by the read- and write-side FIFO pointer blocks.
// Latency: combinational functions only; they hold no state.
// Backpressure: not applicable; this file declares no ports.
package read_pointer_level_pkg;

   // Working width of the conversion functions; callers zero-extend narrower pointers.
   localparam int GRAY_FN_W      = 32;
   localparam int ADDR_SIZE_DEF  = 4;
   localparam int AE_THRESH_DEF  = 2;

   // Pointer width carries one extra wrap bit so that full and empty are distinguishable.
   function automatic int ptr_width(input int addr_size);
      return addr_size + 1;
   endfunction

   function automatic int fifo_depth(input int addr_size);
      return 1 << addr_size;
   endfunction

   // Binary to reflected Gray code.
   function automatic logic [GRAY_FN_W-1:0] bin_to_gray(input logic [GRAY_FN_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Gray to binary: each binary bit is the XOR of its Gray bit and every Gray bit above it.
   function automatic logic [GRAY_FN_W-1:0] gray_decode(input logic [GRAY_FN_W-1:0] g);
      logic [GRAY_FN_W-1:0] b;
      b = '0;
      for (int i = 0; i < GRAY_FN_W; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

endpackage

// File: rtl/read_pointer_level_gray_to_bin.sv
// Width-parametrised Gray to binary converter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows input continuously.
module gray_to_bin
   import read_pointer_level_pkg::*;
#(
   parameter int W = 5
) (
   input  logic [W-1:0] gray_i,
   output logic [W-1:0] bin_o
);

   // Zero-extend into the shared decoder, then keep the low W bits.
   assign bin_o = W'(gray_decode(GRAY_FN_W'(gray_i)));

endmodule

// File: rtl/read_pointer_level.sv
// Read-side FIFO pointer: Gray read pointer, fill level, empty/low-watermark and sticky underflow.
// Latency: all flags and r_ptr are registered one r_clk after w_ptr, r_en or r_flush change.
// Backpressure: reads are suppressed while empty (and flagged as underflow); flush overrides reads.
module read_pointer_level
   import read_pointer_level_pkg::*;
#(
   parameter int ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int AE_THRESH = AE_THRESH_DEF
) (
   input  logic                 r_clk,
   input  logic                 r_rst,
   input  logic [ADDR_SIZE:0]   w_ptr,
   input  logic                 r_en,
   input  logic                 r_flush,
   input  logic                 uf_clr,
   output logic [ADDR_SIZE-1:0] r_addr,
   output logic [ADDR_SIZE:0]   r_ptr,
   output logic                 empty,
   output logic                 almost_empty,
   output logic [ADDR_SIZE:0]   r_level,
   output logic                 underflow
);

   localparam int PW = ptr_width(ADDR_SIZE);

   logic [PW-1:0] wbin;

   logic [PW-1:0] rbin_q,   rbin_d;
   logic [PW-1:0] r_ptr_q,  r_ptr_d;
   logic [PW-1:0] r_level_q, r_level_d;
   logic          empty_q,  empty_d;
   logic          almost_empty_q, almost_empty_d;
   logic          underflow_q, underflow_d;
   logic          rd_fire;

   // Write pointer arrives already synchronised; decode it to binary for level arithmetic.
   gray_to_bin #(.W(PW)) u_w_g2b (
      .gray_i (w_ptr),
      .bin_o  (wbin)
   );

   // Next-state pointer, level and flags; flush jumps straight to the write pointer.
   always_comb begin
      rd_fire        = r_en & ~empty_q;
      rbin_d         = r_flush ? wbin : rbin_q + PW'(rd_fire);
      r_ptr_d        = PW'(bin_to_gray(GRAY_FN_W'(rbin_d)));
      r_level_d      = wbin - rbin_d;
      empty_d        = (r_ptr_d == w_ptr);
      almost_empty_d = (r_level_d <= PW'(AE_THRESH));
      // Setting takes priority over clearing so no underflow event is ever lost.
      underflow_d    = (r_en & empty_q & ~r_flush) | (underflow_q & ~uf_clr);
   end

   // State registers; reset overrides every other control input.
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         rbin_q         <= '0;
         r_ptr_q        <= '0;
         r_level_q      <= '0;
         empty_q        <= 1'b1;
         almost_empty_q <= 1'b1;
         underflow_q    <= 1'b0;
      end else begin
         rbin_q         <= rbin_d;
         r_ptr_q        <= r_ptr_d;
         r_level_q      <= r_level_d;
         empty_q        <= empty_d;
         almost_empty_q <= almost_empty_d;
         underflow_q    <= underflow_d;
      end
   end

   // Memory address uses the current pointer so read data lines up with the present entry.
   assign r_addr       = rbin_q[ADDR_SIZE-1:0];
   assign r_ptr        = r_ptr_q;
   assign r_level      = r_level_q;
   assign empty        = empty_q;
   assign almost_empty = almost_empty_q;
   assign underflow    = underflow_q;

endmodule

// File: tb/tb_read_pointer_level.sv
// Bench for read_pointer_level with ADDR_SIZE=4, AE_THRESH=2.
// Latency: an integer model updated at each r_clk edge is compared every negative edge.
// Backpressure: directed scenarios cover empty reads, flush, wrap and underflow clear.
module tb_read_pointer_level;

   logic       r_clk = 1'b0;
   logic       r_rst;
   logic [4:0] w_ptr;
   logic       r_en;
   logic       r_flush;
   logic       uf_clr;
   logic [3:0] r_addr;
   logic [4:0] r_ptr;
   logic       empty;
   logic       almost_empty;
   logic [4:0] r_level;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   read_pointer_level #(.ADDR_SIZE(4), .AE_THRESH(2)) dut (
      .r_clk        (r_clk),
      .r_rst        (r_rst),
      .w_ptr        (w_ptr),
      .r_en         (r_en),
      .r_flush      (r_flush),
      .uf_clr       (uf_clr),
      .r_addr       (r_addr),
      .r_ptr        (r_ptr),
      .empty        (empty),
      .almost_empty (almost_empty),
      .r_level      (r_level),
      .underflow    (underflow)
   );

   always #5 r_clk = ~r_clk;

   function automatic logic [4:0] g(input int b);
      return 5'(b ^ (b >> 1));
   endfunction

   // Inverse Gray by table search over all 32 codes.
   function automatic int g_inv(input logic [4:0] code);
      for (int i = 0; i < 32; i++) begin
         if (g(i) == code) return i;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: rbin is a plain integer mod 32, level is write minus read.
   int m_rbin  = 0;
   int m_level = 0;
   bit m_empty = 1;
   bit m_under = 0;
   bit m_valid = 0;
   bit m_jump  = 1;

   always @(posedge r_clk) begin
      int wb;
      wb = g_inv(w_ptr);
      m_jump = r_rst | r_flush;
      if (r_rst) begin
         m_rbin  = 0;
         m_level = 0;
         m_empty = 1;
         m_under = 0;
         m_valid = 1;
      end else begin
         if (r_flush)             m_rbin = wb;
         else if (r_en && !m_empty) m_rbin = (m_rbin + 1) % 32;
         if (r_en && m_empty && !r_flush) m_under = 1;
         else if (uf_clr)                 m_under = 0;
         m_level = (wb - m_rbin + 32) % 32;
         m_empty = (m_level == 0);
      end
   end

   logic [4:0] prev_ptr = '0;

   always @(negedge r_clk) begin
      if (m_valid) begin
         chk("m_addr",  int'(r_addr),       m_rbin % 16);
         chk("m_ptr",   int'(r_ptr),        int'(g(m_rbin)));
         chk("m_level", int'(r_level),      m_level);
         chk("m_empty", int'(empty),        int'(m_empty));
         chk("m_ae",    int'(almost_empty), int'(m_level <= 2));
         chk("m_uf",    int'(underflow),    int'(m_under));
         if (!m_jump) chk("m_ptr_onebit", int'($countones(r_ptr ^ prev_ptr) <= 1), 1);
         prev_ptr = r_ptr;
      end
   end

   task automatic tick();
      @(posedge r_clk);
      #1;
   endtask

   initial begin
      r_rst = 1; w_ptr = '0; r_en = 0; r_flush = 0; uf_clr = 0;
      tick(); tick();
      r_rst = 0;
      chk("rst_empty", int'(empty), 1);
      chk("rst_ae",    int'(almost_empty), 1);
      chk("rst_level", int'(r_level), 0);
      chk("rst_ptr",   int'(r_ptr), 0);
      chk("rst_uf",    int'(underflow), 0);

      // Read while empty: underflow, pointer stays.
      r_en = 1; tick(); r_en = 0;
      chk("uf_set",  int'(underflow), 1);
      chk("uf_addr", int'(r_addr), 0);
      uf_clr = 1; tick(); uf_clr = 0;
      chk("uf_clr", int'(underflow), 0);

      // Five entries, then three reads.
      w_ptr = g(5); tick();
      chk("l5_empty", int'(empty), 0);
      chk("l5_level", int'(r_level), 5);
      chk("l5_ae",    int'(almost_empty), 0);
      r_en = 1; tick(); tick(); tick(); r_en = 0;
      chk("l2_level", int'(r_level), 2);
      chk("l2_ae",    int'(almost_empty), 1);
      chk("l2_addr",  int'(r_addr), 3);

      // Full FIFO drained back-to-back.
      r_rst = 1; w_ptr = g(16); tick(); r_rst = 0;
      tick();
      chk("full_level", int'(r_level), 16);
      r_en = 1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         chk("drain_level", int'(r_level), 16 - i);
      end
      r_en = 0;
      chk("drain_empty", int'(empty), 1);
      chk("drain_uf",    int'(underflow), 0);

      // Wrap: park rbin at 30 via flush, write pointer at 2.
      w_ptr = g(30); r_flush = 1; tick(); r_flush = 0;
      w_ptr = g(2); tick();
      chk("wrap_level", int'(r_level), 4);
      chk("wrap_addr0", int'(r_addr), 14);
      r_en = 1;
      tick(); chk("wrap_addr31", int'(r_addr), 15);
      tick(); chk("wrap_addr0b", int'(r_addr), 0);
      tick(); chk("wrap_addr1",  int'(r_addr), 1);
      tick(); chk("wrap_addr2",  int'(r_addr), 2);
      r_en = 0;
      chk("wrap_empty", int'(empty), 1);
      chk("wrap_ptr",   int'(r_ptr), 3);

      // Flush with a simultaneous read.
      w_ptr = g(1); r_flush = 1; tick(); r_flush = 0;
      w_ptr = g(9); tick();
      chk("pre_flush_level", int'(r_level), 8);
      r_flush = 1; r_en = 1; tick(); r_flush = 0; r_en = 0;
      chk("flush_addr",  int'(r_addr), 9);
      chk("flush_empty", int'(empty), 1);
      chk("flush_level", int'(r_level), 0);
      chk("flush_uf",    int'(underflow), 0);

      // Set wins over clear.
      r_en = 1; tick();
      chk("uf2_set", int'(underflow), 1);
      uf_clr = 1; tick();
      chk("uf2_hold", int'(underflow), 1);
      r_en = 0; tick(); uf_clr = 0;
      chk("uf2_clr", int'(underflow), 0);

      // Mid-operation reset.
      w_ptr = g(16); tick();
      r_en = 1; tick();
      r_rst = 1; tick(); r_rst = 0; r_en = 0;
      chk("mrst_level", int'(r_level), 0);
      chk("mrst_ptr",   int'(r_ptr), 0);
      chk("mrst_empty", int'(empty), 1);
      tick();
      chk("mrst_level2", int'(r_level), 16);

      tick(); tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/read_pointer_level.md
READ_POINTER_LEVEL -- requirements
Module: read_pointer_level

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_SIZE, 4, address width; depth = 2**ADDR_SIZE, pointers ADDR_SIZE+1 bits.
  AE_THRESH, 2, almost_empty asserts when next level <= AE_THRESH (0..2**ADDR_SIZE).
REQ-002 Ports SHALL be, one per line (name direction width meaning):
  r_clk  in  1  read-domain clock.
  r_rst  in  1  synchronous, active-high reset.
  w_ptr  in  ADDR_SIZE+1  write pointer, Gray, already synchronised into r_clk.
  r_en  in  1  read request.
  r_flush  in  1  discard all stored entries.
  uf_clr  in  1  clear sticky underflow.
  r_addr  out  ADDR_SIZE  memory read address.
  r_ptr  out  ADDR_SIZE+1  registered Gray read pointer, to write domain.
  empty  out  1  registered empty flag.
  almost_empty  out  1  registered low-watermark flag.
  r_level  out  ADDR_SIZE+1  registered entry count, 0..2**ADDR_SIZE.
  underflow  out  1  sticky: read attempted while empty.
REQ-003 One clock and one reset SHALL be used: r_clk, with synchronous active-high reset r_rst.

Function
REQ-004 The block SHALL keep binary read counter rbin (ADDR_SIZE+1 bits, modulo 2**(ADDR_SIZE+1)).
REQ-005 w_ptr SHALL be converted combinationally Gray->binary to wbin.
REQ-006 rd_fire = r_en & ~empty; bin_next = r_flush ? wbin : rbin + rd_fire.
REQ-007 r_flush SHALL take priority over r_en; a read in the flush cycle is dropped, not counted as underflow.
REQ-008 On each r_clk edge rbin <= bin_next and r_ptr <= Gray(bin_next).
REQ-009 r_addr SHALL equal rbin[ADDR_SIZE-1:0] (current, not next, pointer).
REQ-010 level_next = (wbin - bin_next) mod 2**(ADDR_SIZE+1); r_level <= level_next each cycle.
REQ-011 empty <= (Gray(bin_next) == w_ptr); latency from w_ptr change to empty deassertion: 1 cycle.
REQ-012 almost_empty <= (level_next <= AE_THRESH); empty implies almost_empty.
REQ-013 underflow SHALL set when r_en & empty & ~r_flush; stays set until uf_clr or reset; set wins over uf_clr in same cycle.
REQ-014 Pointer wrap past 2**(ADDR_SIZE+1)-1 SHALL return to 0 with no discontinuity in r_level/empty.
REQ-015 r_ptr SHALL change by at most one Gray bit per cycle except in a flush cycle.

Reset
REQ-016 With r_rst high at an r_clk edge: rbin=0, r_ptr=0, r_level=0, empty=1, almost_empty=1, underflow=0.
REQ-017 Reset SHALL override r_flush, r_en and uf_clr; mid-operation reset discards counter state in one cycle.
REQ-018 No output SHALL change asynchronously to r_clk.

Structure
REQ-019 A shared package SHALL hold pointer-width localparam helpers and Gray<->binary conversion functions, shared with the write-side pointer block.
REQ-020 Existing bin_to_gray SHALL be reused; one new sub-module gray_to_bin (parametrised width) SHALL be added.
REQ-021 Target size 120-250 RTL lines; no memory inside this block.

Verification (ADDR_SIZE=4, AE_THRESH=2)
REQ-022 Reset, w_ptr=0 -> empty=1, almost_empty=1, r_level=0, r_ptr=0; r_en pulse -> underflow=1, rbin stays 0.
REQ-023 w_ptr=Gray(5), no reads -> next cycle empty=0, r_level=5, almost_empty=0; 3 reads -> r_level=2, almost_empty=1, r_addr=3.
REQ-024 w_ptr=Gray(16), 16 back-to-back reads -> r_level 16..0, empty=1 after last read, no underflow.
REQ-025 Start rbin=30, w_ptr=Gray(2) -> r_level=4; 4 reads -> rbin wraps 31,0,1,2, empty=1.
REQ-026 w_ptr=Gray(9), rbin=1, r_flush with r_en -> rbin=9, empty=1, r_level=0, underflow=0.
REQ-027 underflow set, uf_clr with r_en&empty same cycle -> underflow stays 1; uf_clr alone -> 0.
